// File: rtl/shadow_capture_bank.sv
// Multi-channel shadow capture FIFO: snapshots CHANNELS words per capture strobe
// into a DEPTH-entry store and drains the head snapshot one channel word at a time.

module scb_lane #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int PW    = 2
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PW-1:0]    wr_ptr,
    input  logic [WIDTH-1:0] wd,
    input  logic [PW-1:0]    rd_ptr,
    output logic [WIDTH-1:0] rd
);
    // Storage carries no reset; contents are only observed once written.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_ptr] <= wd;

    assign rd = mem[rd_ptr];
endmodule

module shadow_capture_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    parameter int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int AW       = $clog2(DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cap_en,
    input  logic [CHANNELS*WIDTH-1:0] din,
    input  logic                      clr_ovf,
    input  logic                      q_rd,
    output logic                      q_ready,
    output logic [WIDTH-1:0]          q,
    output logic [CW-1:0]             q_chan,
    output logic                      q_last,
    output logic [AW-1:0]             count,
    output logic                      full,
    output logic                      empty,
    output logic                      overflow
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PW-1:0]                   wr_ptr, rd_ptr;
    logic [CW-1:0]                   chan;
    logic [CHANNELS-1:0][WIDTH-1:0]  lane_rd;
    logic                            at_last, xfer, pop, push, drop;

    assign empty   = (count == '0);
    assign full    = (count == AW'(DEPTH));
    assign q_ready = !empty;
    assign at_last = (chan == CW'(CHANNELS - 1));
    assign q_last  = q_ready && at_last;
    assign q_chan  = chan;

    assign xfer = q_ready && q_rd;
    assign pop  = xfer && at_last;
    // A pop on the same edge frees the head slot, so a full bank still accepts.
    assign push = cap_en && (!full || pop);
    assign drop = cap_en && !push;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        scb_lane #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PW(PW)) u_lane (
            .clk    (clk),
            .wr_en  (push),
            .wr_ptr (wr_ptr),
            .wd     (din[g*WIDTH +: WIDTH]),
            .rd_ptr (rd_ptr),
            .rd     (lane_rd[g])
        );
    end

    assign q = empty ? '0 : lane_rd[chan];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            chan     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            if (xfer)
                chan <= at_last ? '0 : chan + CW'(1);
            if (push && !pop)
                count <= count + AW'(1);
            else if (pop && !push)
                count <= count - AW'(1);
            // Set beats clear so a drop is never lost to a concurrent clear.
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shadow_capture_bank.sv
// Directed bench for shadow_capture_bank with hand-computed expected values.

module tb_shadow_capture_bank;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cap_en;
    logic [31:0] din;
    logic        clr_ovf;
    logic        q_rd;
    logic        q_ready;
    logic [7:0]  q;
    logic [1:0]  q_chan;
    logic        q_last;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int n_cmp = 0;
    int n_err = 0;

    shadow_capture_bank #(.WIDTH(8), .CHANNELS(4), .DEPTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cap_en   (cap_en),
        .din      (din),
        .clr_ovf  (clr_ovf),
        .q_rd     (q_rd),
        .q_ready  (q_ready),
        .q        (q),
        .q_chan   (q_chan),
        .q_last   (q_last),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [31:0] d);
        cap_en = 1'b1;
        din    = d;
        tick();
        cap_en = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b;

        // 1. reset with arbitrary inputs
        rst_n = 1'b0; cap_en = 1'b1; din = 32'hDEADBEEF; clr_ovf = 1'b0; q_rd = 1'b1;
        repeat (3) tick();
        cap_en = 1'b0; q_rd = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rst_q_ready",  32'(q_ready),  32'd0);
        chk("rst_empty",    32'(empty),    32'd1);
        chk("rst_full",     32'(full),     32'd0);
        chk("rst_count",    32'(count),    32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_q",        32'(q),        32'd0);
        chk("rst_q_chan",   32'(q_chan),   32'd0);
        chk("rst_q_last",   32'(q_last),   32'd0);

        // q_rd while empty does nothing
        q_rd = 1'b1;
        tick();
        chk("empty_rd_count", 32'(count),  32'd0);
        chk("empty_rd_chan",  32'(q_chan), 32'd0);

        // 2. single capture drained with q_rd held
        capture(32'hFECDAB12);
        chk("single_count", 32'(count), 32'd1);
        chk("single_w0",    32'(q),      32'h12);
        chk("single_c0",    32'(q_chan), 32'd0);
        chk("single_l0",    32'(q_last), 32'd0);
        tick();
        chk("single_w1",    32'(q),      32'hAB);
        chk("single_c1",    32'(q_chan), 32'd1);
        chk("single_l1",    32'(q_last), 32'd0);
        tick();
        chk("single_w2",    32'(q),      32'hCD);
        chk("single_c2",    32'(q_chan), 32'd2);
        tick();
        chk("single_w3",    32'(q),      32'hFE);
        chk("single_c3",    32'(q_chan), 32'd3);
        chk("single_l3",    32'(q_last), 32'd1);
        tick();
        chk("single_empty", 32'(empty),   32'd1);
        chk("single_rdy",   32'(q_ready), 32'd0);
        chk("single_q0",    32'(q),       32'd0);

        // 3. fill and overflow
        q_rd = 1'b0;
        capture(32'h11111111);
        capture(32'h22222222);
        capture(32'h33333333);
        capture(32'h44444444);
        chk("fill_full",  32'(full),     32'd1);
        chk("fill_count", 32'(count),    32'd4);
        chk("fill_ovf0",  32'(overflow), 32'd0);
        capture(32'h55555555);
        chk("ovf_set",    32'(overflow), 32'd1);
        chk("ovf_count",  32'(count),    32'd4);
        q_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_b = 8'h11 * 8'(i / 4 + 1);
            chk("fill_drain_w", 32'(q),      32'(exp_b));
            chk("fill_drain_c", 32'(q_chan), 32'(i % 4));
            tick();
        end
        chk("fill_drained", 32'(empty), 32'd1);
        q_rd = 1'b0; clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);

        // 4. full with simultaneous pop
        capture(32'h13121110);
        capture(32'h23222120);
        capture(32'h33323130);
        capture(32'h43424140);
        chk("fp_q0", 32'(q), 32'h10);
        q_rd = 1'b1;
        repeat (3) tick();
        chk("fp_chan3", 32'(q_chan), 32'd3);
        chk("fp_w3",    32'(q),      32'h13);
        chk("fp_last",  32'(q_last), 32'd1);
        capture(32'hA5A5A5A5);
        chk("fp_count", 32'(count),    32'd4);
        chk("fp_full",  32'(full),     32'd1);
        chk("fp_ovf",   32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) begin
            exp_b = (i < 12) ? 8'(8'h20 + 8'((i / 4) * 16) + 8'(i % 4)) : 8'hA5;
            chk("fp_drain_w", 32'(q),      32'(exp_b));
            chk("fp_drain_c", 32'(q_chan), 32'(i % 4));
            tick();
        end
        chk("fp_drained", 32'(empty), 32'd1);

        // 5. overflow set beats clear
        q_rd = 1'b0;
        capture(32'h01010101);
        capture(32'h02020202);
        capture(32'h03030303);
        capture(32'h04040404);
        clr_ovf = 1'b1;
        capture(32'h09090909);
        chk("prio_ovf_set", 32'(overflow), 32'd1);
        chk("prio_count",   32'(count),    32'd4);
        tick();
        clr_ovf = 1'b0;
        chk("prio_ovf_clr", 32'(overflow), 32'd0);

        // 6. reset mid-drain
        q_rd = 1'b1;
        repeat (2) tick();
        chk("mid_chan2", 32'(q_chan), 32'd2);
        chk("mid_w2",    32'(q),      32'h01);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rdy",   32'(q_ready), 32'd0);
        chk("mid_rst_count", 32'(count),   32'd0);
        chk("mid_rst_empty", 32'(empty),   32'd1);
        q_rd = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        capture(32'h0BADF00D);
        chk("post_w0",    32'(q),      32'h0D);
        chk("post_c0",    32'(q_chan), 32'd0);
        chk("post_count", 32'(count),  32'd1);
        q_rd = 1'b1;
        tick();
        chk("post_w1", 32'(q), 32'hF0);
        tick();
        chk("post_w2", 32'(q), 32'hAD);
        tick();
        chk("post_w3",   32'(q),      32'h0B);
        chk("post_last", 32'(q_last), 32'd1);
        // capture+pop at count==1 leaves the new head at channel 0
        capture(32'h76543210);
        chk("cp1_rdy",   32'(q_ready), 32'd1);
        chk("cp1_count", 32'(count),   32'd1);
        chk("cp1_chan",  32'(q_chan),  32'd0);
        chk("cp1_w0",    32'(q),       32'h10);
        q_rd = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/shadow_capture_bank.md
Name: shadow_capture_bank

Overview:
Multi-channel shadow capture buffer. On a capture strobe it snapshots CHANNELS parallel WIDTH-bit words into a DEPTH-entry snapshot FIFO. It then drains each snapshot one channel word at a time over a valid/ready handshake. It is the single-clock, multi-entry successor to the single-register shadow flop and feeds the capture readout path.

Parameters:
WIDTH, 8, bits per channel word
CHANNELS, 4, channel words per snapshot (>=1)
DEPTH, 4, snapshot entries held (>=2; need not be a power of two)
CW, max(1,$clog2(CHANNELS)), derived: channel index width
AW, $clog2(DEPTH+1), derived: occupancy count width

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cap_en  in  1  capture strobe; samples din at this edge
din  in  CHANNELS*WIDTH  snapshot data; channel k = din[k*WIDTH +: WIDTH]
clr_ovf  in  1  clears sticky overflow
q_rd  in  1  consumer ready for current word
q_ready  out  1  q/q_chan/q_last valid (FIFO non-empty)
q  out  WIDTH  current channel word of head snapshot
q_chan  out  CW  channel index of q
q_last  out  1  q is the final channel of the head snapshot
count  out  AW  snapshots stored (0..DEPTH)
full  out  1  count==DEPTH
empty  out  1  count==0
overflow  out  1  sticky: a capture was dropped

Behaviour:
- Reset (rst_n low, async): wr_ptr=rd_ptr=0, chan=0, count=0, overflow=0. Outputs q_ready=0, q_chan=0, q_last=0, full=0, empty=1, overflow=0. Storage contents are don't-care. q is driven 0 while empty.
- Reset asserted mid-operation aborts any in-progress drain immediately. After release, the next snapshot drains from channel 0.
- Capture (cap_en=1 at an edge):
  - If not full, or if a pop occurs in the same edge: write all of din to entry wr_ptr and advance wr_ptr.
  - Otherwise drop the snapshot and set overflow.
- Pointers wrap DEPTH-1 -> 0.
- Transfer occurs when q_ready && q_rd at an edge:
  - If chan<CHANNELS-1: chan increments.
  - Else (q_last): chan=0 and pop (rd_ptr advances).
- q_rd while empty has no effect.
- q = entry[rd_ptr] channel chan. This is a combinational mux from registered state; no output register.
- q_last = q_ready && (chan==CHANNELS-1). When CHANNELS=1, q_chan is always 0 and every valid word is last.
- Latency: a capture at edge N into an empty FIFO gives q_ready=1, q=channel 0 after edge N. Draining a full snapshot takes CHANNELS transfer cycles minimum.
- count updates:
  - +1 on an accepted capture with no pop.
  - -1 on a pop with no capture.
  - Unchanged on capture+pop.
  - A capture+pop when full is accepted; count stays DEPTH.
  - A capture+pop when count==1 leaves q_ready=1, with the new head at channel 0.
- full, empty and q_ready are decoded from count.
- overflow is sticky until clr_ovf. If a drop and clr_ovf occur in the same edge, set wins and overflow stays 1.
- The head snapshot is stable while draining; writes never target rd_ptr unless that entry is being popped in the same edge.
- din is sampled only on cap_en edges.

Test Plan:
1. Reset: hold rst_n=0 with arbitrary inputs, release → q_ready=0, empty=1, full=0, count=0, overflow=0, q=0.
2. Single capture: din=32'hFECDAB12, cap_en 1 cycle, q_rd=1 → q=12,AB,CD,FE on successive cycles; q_chan 0..3; q_last only with FE; then empty=1.
3. Fill and overflow: q_rd=0, capture 32'h11111111, 22222222, 33333333, 44444444 → full=1, count=4. Fifth capture 55555555 → dropped, overflow=1. Drain yields all 11s, 22s, 33s, 44s words in order, with no 55.
4. Full with simultaneous pop: with count=4 and head at chan=3, assert q_rd=1 and cap_en=1 with 32'hA5A5A5A5 → count stays 4, overflow stays 0, A5 snapshot drains last.
5. Overflow clear priority: full, then cap_en=1 and clr_ovf=1 in the same edge → overflow=1. Next edge with clr_ovf alone → overflow=0.
6. Reset mid-drain: q_rd held 1, pulse rst_n low when q_chan=2 → q_ready=0 and count=0 asynchronously. Capture 32'h0BADF00D after release → q=0D first, q_chan=0.
